// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared types, constants and the hex-to-segment lookup
//                for the multiplexed 7-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    // Active-low segment byte {A,B,C,D,E,F,G,DP}
    typedef logic [7:0] seg_t;

    // All segments (and DP) off
    localparam seg_t SEG_BLANK = 8'hFF;

    // Active-low A..G pattern for a hex nibble (bit 6 = A, bit 0 = G)
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b0000001;
            4'h1:    pat = 7'b1001111;
            4'h2:    pat = 7'b0010010;
            4'h3:    pat = 7'b0000110;
            4'h4:    pat = 7'b1001100;
            4'h5:    pat = 7'b0100100;
            4'h6:    pat = 7'b0100000;
            4'h7:    pat = 7'b0001111;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0000100;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b1100000;
            4'hC:    pat = 7'b0110001;
            4'hD:    pat = 7'b1000010;
            4'hE:    pat = 7'b0110000;
            default: pat = 7'b0111000;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_timer
//  Description : Slot prescaler and digit index counter. Decodes the blank /
//                show phase of the current slot and the frame-start cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_timer #(
    parameter int N_DIGITS  = 5,
    parameter int DIV       = 65536,
    parameter int BLANK_CYC = 256,
    parameter int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] index,
    output logic             show,
    output logic             snap
);

    localparam int P_W = $clog2(DIV);

    logic [P_W-1:0]   p_q,   p_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Prescaler wraps at DIV-1; the digit index advances on each wrap
    always_comb begin
        p_d   = p_q + 1'b1;
        idx_d = idx_q;
        if (p_q == P_W'(DIV - 1)) begin
            p_d = '0;
            if (idx_q == IDX_W'(N_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Counter state; reset restarts the scan at digit 0, slot start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q   <= '0;
            idx_q <= '0;
        end else begin
            p_q   <= p_d;
            idx_q <= idx_d;
        end
    end

    assign index = idx_q;
    assign show  = (p_q >= P_W'(BLANK_CYC));
    assign snap  = (p_q == '0) && (idx_q == '0);

endmodule
`default_nettype wire

// File: rtl/sseg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_mux
//  Description : Time-multiplexed hex driver for common-anode 7-segment
//                banks. Per-digit enable and decimal point, inter-digit
//                blanking gap, once-per-frame input snapshot.
//                Optional leading-zero blanking when SSEG_LZB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int N_DIGITS  = 5,
    parameter int N_ANODES  = 8,
    parameter int DIV       = 65536,
    parameter int BLANK_CYC = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   digit_en,
    output logic [N_ANODES-1:0]   anode,
    output logic [7:0]            seg,
    output logic                  frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [IDX_W-1:0] index;
    logic             show;
    logic             snap;

    sseg_scan_timer #(
        .N_DIGITS  (N_DIGITS),
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC),
        .IDX_W     (IDX_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .index (index),
        .show  (show),
        .snap  (snap)
    );

    logic [4*N_DIGITS-1:0] data_q, data_d;
    logic [N_DIGITS-1:0]   dp_q,   dp_d;
    logic [N_DIGITS-1:0]   en_q,   en_d;
    logic [N_ANODES-1:0]   anode_q, anode_d;
    seg_t                  seg_q,  seg_d;
    logic                  tick_q, tick_d;

    logic [N_DIGITS-1:0]   lzb_mask;
    logic [N_DIGITS-1:0]   en_vis;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_en;

    // Inputs are frozen at frame start so a frame never mixes old and new values
    always_comb begin
        data_d = snap ? data     : data_q;
        dp_d   = snap ? dp       : dp_q;
        en_d   = snap ? digit_en : en_q;
    end

`ifdef SSEG_LZB_EN
    logic lzb_keep;

    // Walk down from the top digit; once a nonzero nibble or a set DP is seen,
    // that digit and everything below it stays visible. Digit 0 always shows.
    always_comb begin
        lzb_keep = 1'b0;
        lzb_mask = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            lzb_keep    = lzb_keep | (data_q[4*i +: 4] != 4'h0) | dp_q[i] | (i == 0);
            lzb_mask[i] = lzb_keep;
        end
    end
`else
    assign lzb_mask = '1;
`endif

    assign en_vis = en_q & lzb_mask;

    // Select the current digit and build the next output pattern
    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (index == IDX_W'(i)) begin
                cur_nib = data_q[4*i +: 4];
                cur_dp  = dp_q[i];
                cur_en  = en_vis[i];
            end
        end

        anode_d = '1;
        seg_d   = SEG_BLANK;
        if (show) begin
            // Segments are driven even for a dark digit; its anode stays off
            seg_d = {hex2seg(cur_nib), ~cur_dp};
            for (int i = 0; i < N_DIGITS; i++) begin
                if ((index == IDX_W'(i)) && cur_en) begin
                    anode_d[i] = 1'b0;
                end
            end
        end

        tick_d = snap;
    end

    // Snapshot and output registers; reset darkens the display immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            dp_q    <= '0;
            en_q    <= '0;
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
            tick_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            dp_q    <= dp_d;
            en_q    <= en_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            tick_q  <= tick_d;
        end
    end

    assign anode      = anode_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_scan_mux
//  Description : Self-checking bench for sseg_scan_mux (4 digits, 8 anodes,
//                8-cycle slots, 2-cycle blanking gap). Expected outputs come
//                from a cycle-count model of the scan schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_mux;

    localparam int N_DIG = 4;
    localparam int N_AN  = 8;
    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = N_DIG * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [7:0]  anode;
    logic [7:0]  seg;
    logic        frame_tick;

    always #5 clk = ~clk;

    sseg_scan_mux #(
        .N_DIGITS  (N_DIG),
        .N_ANODES  (N_AN),
        .DIV       (DIV),
        .BLANK_CYC (BLK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp         (dp),
        .digit_en   (en),
        .anode      (anode),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: cycles since reset release, and the frame snapshot
    int          cyc;
    int          m_cyc;
    int          m_p;
    int          m_idx;
    logic [15:0] s_data;
    logic [3:0]  s_dp;
    logic [3:0]  s_en;
    logic [7:0]  exp_anode;
    logic [7:0]  exp_seg;
    logic        exp_tick;
    logic [3:0]  nib;

    logic [6:0] lut [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Digit visibility from the frozen snapshot
    function automatic bit visible(int idx);
        bit v;
        v = s_en[idx];
`ifdef SSEG_LZB_EN
        if (idx != 0) begin
            bit any;
            any = 1'b0;
            for (int j = idx; j < N_DIG; j++) begin
                if (s_data[j*4 +: 4] != 4'h0 || s_dp[j]) any = 1'b1;
            end
            v = v && any;
        end
`endif
        return v;
    endfunction

    // Advance one clock and compute what the outputs must show after it
    task automatic step();
        @(posedge clk);
        if (cyc % FRAME == 0) begin
            s_data = data;
            s_dp   = dp;
            s_en   = en;
        end
        m_cyc     = cyc;
        m_p       = cyc % DIV;
        m_idx     = (cyc / DIV) % N_DIG;
        exp_tick  = (cyc % FRAME == 0);
        exp_anode = 8'hFF;
        exp_seg   = 8'hFF;
        if (m_p >= BLK) begin
            nib     = s_data[m_idx*4 +: 4];
            exp_seg = {lut[nib], ~s_dp[m_idx]};
            if (visible(m_idx)) exp_anode[m_idx] = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        data = 16'h12A0;
        dp   = 4'h0;
        en   = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (anode !== 8'hFF) begin
            n_fail++; $display("FAIL reset_anode: got %h, want ff", anode);
        end
        n_checks++;
        if (seg !== 8'hFF) begin
            n_fail++; $display("FAIL reset_seg: got %h, want ff", seg);
        end
        n_checks++;
        if (frame_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_tick: got %b, want 0", frame_tick);
        end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_digit0();
        for (int k = 0; k < DIV; k++) begin
            step();
            n_checks++;
            if (anode !== exp_anode) begin
                n_fail++; $display("FAIL d0_anode c%0d: got %h, want %h", m_cyc, anode, exp_anode);
            end
            n_checks++;
            if (seg !== exp_seg) begin
                n_fail++; $display("FAIL d0_seg c%0d: got %h, want %h", m_cyc, seg, exp_seg);
            end
            n_checks++;
            if (frame_tick !== exp_tick) begin
                n_fail++; $display("FAIL d0_tick c%0d: got %b, want %b", m_cyc, frame_tick, exp_tick);
            end
            if (m_p >= BLK) begin
                n_checks++;
                if (anode !== 8'hFE || seg !== 8'b00000011) begin
                    n_fail++; $display("FAIL d0_show c%0d: got %h/%b, want fe/00000011", m_cyc, anode, seg);
                end
            end
        end
    endtask

    task automatic test_scan();
        int ticks;
        logic [7:0] want_seg;
        ticks = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            step();
            if (frame_tick === 1'b1) ticks++;
            n_checks++;
            if (anode !== exp_anode) begin
                n_fail++; $display("FAIL scan_anode c%0d: got %h, want %h", m_cyc, anode, exp_anode);
            end
            n_checks++;
            if (seg !== exp_seg) begin
                n_fail++; $display("FAIL scan_seg c%0d: got %h, want %h", m_cyc, seg, exp_seg);
            end
            n_checks++;
            if (frame_tick !== exp_tick) begin
                n_fail++; $display("FAIL scan_tick c%0d: got %b, want %b", m_cyc, frame_tick, exp_tick);
            end
            if (m_p >= BLK && m_idx != 0) begin
                want_seg = (m_idx == 1) ? 8'b00010001 :
                           (m_idx == 2) ? 8'b00100101 : 8'b10011111;
                n_checks++;
                if (seg !== want_seg) begin
                    n_fail++; $display("FAIL scan_digit c%0d: got %b, want %b", m_cyc, seg, want_seg);
                end
            end
        end
        n_checks++;
        if (ticks !== 3) begin
            n_fail++; $display("FAIL scan_tick_count: got %0d, want 3", ticks);
        end
    endtask

    // Entered at the start of a digit-1 slot
    task automatic test_freeze();
        data = 16'hFFFF;
        for (int k = 0; k < 56; k++) begin
            step();
            n_checks++;
            if (anode !== exp_anode) begin
                n_fail++; $display("FAIL frz_anode c%0d: got %h, want %h", m_cyc, anode, exp_anode);
            end
            n_checks++;
            if (seg !== exp_seg) begin
                n_fail++; $display("FAIL frz_seg c%0d: got %h, want %h", m_cyc, seg, exp_seg);
            end
            n_checks++;
            if (frame_tick !== exp_tick) begin
                n_fail++; $display("FAIL frz_tick c%0d: got %b, want %b", m_cyc, frame_tick, exp_tick);
            end
            if (m_p >= BLK && m_cyc >= 128) begin
                n_checks++;
                if (seg !== 8'b01110001) begin
                    n_fail++; $display("FAIL frz_new c%0d: got %b, want 01110001", m_cyc, seg);
                end
            end
        end
    endtask

    // Entered at a frame boundary
    task automatic test_enable_dp();
        int lows2;
        int lows3;
        logic want_dp;
        lows2 = 0;
        lows3 = 0;
        en = 4'b1011;
        dp = 4'b0100;
        for (int k = 0; k < 3 * FRAME; k++) begin
            step();
            if (anode[2] === 1'b0) lows2++;
            if (anode[3] === 1'b0) lows3++;
            n_checks++;
            if (anode !== exp_anode) begin
                n_fail++; $display("FAIL en_anode c%0d: got %h, want %h", m_cyc, anode, exp_anode);
            end
            n_checks++;
            if (seg !== exp_seg) begin
                n_fail++; $display("FAIL en_seg c%0d: got %h, want %h", m_cyc, seg, exp_seg);
            end
            n_checks++;
            if (frame_tick !== exp_tick) begin
                n_fail++; $display("FAIL en_tick c%0d: got %b, want %b", m_cyc, frame_tick, exp_tick);
            end
            if (m_p >= BLK) begin
                want_dp = (m_idx == 2) ? 1'b0 : 1'b1;
                n_checks++;
                if (seg[0] !== want_dp) begin
                    n_fail++; $display("FAIL en_dp c%0d: got %b, want %b", m_cyc, seg[0], want_dp);
                end
            end
        end
        n_checks++;
        if (lows2 !== 0) begin
            n_fail++; $display("FAIL en_anode2_lows: got %0d, want 0", lows2);
        end
        n_checks++;
        if (lows3 !== 18) begin
            n_fail++; $display("FAIL en_anode3_lows: got %0d, want 18", lows3);
        end
    endtask

    // Entered at a frame boundary; three frames with different patterns
    task automatic test_lzb();
        int lows;
        int want;
        en = 4'hF;
        for (int f = 0; f < 3; f++) begin
            case (f)
                0: begin data = 16'h0045; dp = 4'b0000; end
                1: begin data = 16'h0000; dp = 4'b0000; end
                default: begin data = 16'h0000; dp = 4'b1000; end
            endcase
            lows = 0;
            for (int k = 0; k < FRAME; k++) begin
                step();
                for (int b = 0; b < N_DIG; b++) begin
                    if (anode[b] === 1'b0) lows++;
                end
                n_checks++;
                if (anode !== exp_anode) begin
                    n_fail++; $display("FAIL lzb_anode c%0d: got %h, want %h", m_cyc, anode, exp_anode);
                end
                n_checks++;
                if (seg !== exp_seg) begin
                    n_fail++; $display("FAIL lzb_seg c%0d: got %h, want %h", m_cyc, seg, exp_seg);
                end
            end
`ifdef SSEG_LZB_EN
            want = (f == 0) ? 12 : (f == 1) ? 6 : 24;
`else
            want = 24;
`endif
            n_checks++;
            if (lows !== want) begin
                n_fail++; $display("FAIL lzb_lit_slots f%0d: got %0d, want %0d", f, lows, want);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 8 * FRAME; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                data = 16'($urandom);
                dp   = 4'($urandom);
                en   = 4'($urandom);
            end
            step();
            n_checks++;
            if (anode !== exp_anode) begin
                n_fail++; $display("FAIL rnd_anode c%0d: got %h, want %h", m_cyc, anode, exp_anode);
            end
            n_checks++;
            if (seg !== exp_seg) begin
                n_fail++; $display("FAIL rnd_seg c%0d: got %h, want %h", m_cyc, seg, exp_seg);
            end
            n_checks++;
            if (frame_tick !== exp_tick) begin
                n_fail++; $display("FAIL rnd_tick c%0d: got %b, want %b", m_cyc, frame_tick, exp_tick);
            end
        end
    endtask

    // Entered at a frame boundary
    task automatic test_reset_mid();
        bit hit;
        hit  = 1'b0;
        data = 16'h3210;
        dp   = 4'h0;
        en   = 4'hF;
        for (int k = 0; k < FRAME && !hit; k++) begin
            step();
            n_checks++;
            if (anode !== exp_anode) begin
                n_fail++; $display("FAIL rm_pre_anode c%0d: got %h, want %h", m_cyc, anode, exp_anode);
            end
            if (m_idx == 2 && m_p == 4) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++; $display("FAIL rm_reach_slot2: got no digit-2 show cycle, want one");
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (anode !== 8'hFF) begin
            n_fail++; $display("FAIL rm_async_anode: got %h, want ff", anode);
        end
        n_checks++;
        if (seg !== 8'hFF) begin
            n_fail++; $display("FAIL rm_async_seg: got %h, want ff", seg);
        end
        @(posedge clk);
        #1;
        data = 16'h9876;
        rst  = 1'b0;
        cyc  = 0;
        for (int k = 0; k < 2 * DIV; k++) begin
            step();
            n_checks++;
            if (anode !== exp_anode) begin
                n_fail++; $display("FAIL rm_anode c%0d: got %h, want %h", m_cyc, anode, exp_anode);
            end
            n_checks++;
            if (seg !== exp_seg) begin
                n_fail++; $display("FAIL rm_seg c%0d: got %h, want %h", m_cyc, seg, exp_seg);
            end
            n_checks++;
            if (frame_tick !== (k == 0)) begin
                n_fail++; $display("FAIL rm_tick c%0d: got %b, want %b", m_cyc, frame_tick, (k == 0));
            end
            if (k < BLK) begin
                n_checks++;
                if (anode !== 8'hFF || seg !== 8'hFF) begin
                    n_fail++; $display("FAIL rm_blank c%0d: got %h/%h, want ff/ff", m_cyc, anode, seg);
                end
            end else if (k < DIV) begin
                n_checks++;
                if (seg !== {lut[6], 1'b1}) begin
                    n_fail++; $display("FAIL rm_fresh c%0d: got %b, want %b", m_cyc, seg, {lut[6], 1'b1});
                end
            end
        end
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_digit0();
        test_scan();
        test_freeze();
        test_enable_dp();
        test_lzb();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
